// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
// Provides default widths, the kernel size constant and a saturation helper
// that clamps a wide signed value into a signed range of a given bit width.
package cnn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int OUT_W_DEF  = 9;
  localparam int K          = 3;
  localparam int TAPS       = K * K;

  // Clamp value into [-2^(out_w-1), 2^(out_w-1)-1]; the caller keeps the low
  // out_w bits of the result.
  function automatic logic signed [31:0] saturate(input logic signed [63:0] value,
                                                  input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi[31:0];
    if (value < lo) return lo[31:0];
    return value[31:0];
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One-row delay line for the 3x3 window.
// Each enabled cycle pushes din in; dout is the sample pushed DEPTH enables
// earlier, i.e. the pixel directly above the current one in the frame.
// Ports: clk, rst_n (async active-low), en (shift enable), din, dout.
module conv_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 "valid" convolution over an IMG_W x IMG_H raster pixel stream.
// Emits one saturated signed result per fully interior window, with a
// runtime-loadable kernel and valid/ready flow control on both sides.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   coef_we/coef_addr/coef_data    kernel write (index 0..8 row-major), only while idle
//   s_valid/s_ready/s_data         unsigned pixel input stream
//   m_valid/m_ready/m_data/m_last  signed saturated result stream, m_last ends a frame
//   busy                           frame in flight (first pixel accepted .. last result consumed)
module conv3x3_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_last,
  output logic                     busy
);

  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = PW + 4;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic en;
  logic accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic col_end, row_end, win_ok, frame_first, frame_last;
  logic [DATA_W-1:0] lb0_out, lb1_out;
  logic [DATA_W-1:0] tap [TAPS];
  logic [DATA_W-1:0] win [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PW-1:0] prod [TAPS];
  logic tap_valid, tap_last, v1, l1, v2, l2;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  // The whole pipeline advances together unless a result is being held.
  assign en      = !(m_valid && !m_ready);
  assign s_ready = en;
  assign accept  = s_valid && en;

  assign col_end     = (col == CW'(IMG_W - 1));
  assign row_end     = (row == RW'(IMG_H - 1));
  assign win_ok      = (row >= RW'(2)) && (col >= CW'(2));
  assign frame_first = (row == '0) && (col == '0);
  assign frame_last  = row_end && col_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // lb0 yields the pixel one row above the incoming one, lb1 two rows above.
  conv_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(accept), .din(s_data), .dout(lb0_out)
  );
  conv_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(accept), .din(lb0_out), .dout(lb1_out)
  );

  // Window shift: columns move left, the new right column is top/mid/bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        tap[r*K]   <= tap[r*K+1];
        tap[r*K+1] <= tap[r*K+2];
      end
      tap[2] <= lb1_out;
      tap[5] <= lb0_out;
      tap[8] <= s_data;
    end
  end

  // Kernel writes are locked out while a frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_we && !busy) begin
      for (int i = 0; i < TAPS; i++)
        if (coef_addr == 4'(i)) coef[i] <= coef_data;
    end
  end

  // Pipeline: window flags, window snapshot, products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_valid <= 1'b0;
      tap_last  <= 1'b0;
      v1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        win[i]  <= '0;
        prod[i] <= '0;
      end
    end else if (en) begin
      tap_valid <= accept && win_ok;
      tap_last  <= accept && frame_last;
      v1        <= tap_valid;
      l1        <= tap_last;
      v2        <= v1;
      l2        <= l1;
      for (int i = 0; i < TAPS; i++) begin
        win[i]  <= tap[i];
        prod[i] <= PW'($signed({1'b0, win[i]})) * PW'(coef[i]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) sum = sum + SW'(prod[i]);
  end

  assign shifted = sum >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (en) begin
      m_valid <= v2;
      m_last  <= v2 && l2;
      if (v2) m_data <= OUT_W'(saturate(64'(shifted), OUT_W));
    end
  end

  // A new frame's first pixel wins over the consumption of the previous m_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else if (accept && frame_first) begin
      busy <= 1'b1;
    end else if (m_valid && m_ready && m_last) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
module tb_conv3x3_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic m_ready = 1'b1;

  logic s_ready, m_valid, m_last, busy;
  logic signed [8:0] m_data;
  logic s_ready_s2, m_valid_s2, m_last_s2, busy_s2;
  logic signed [8:0] m_data_s2;

  always #5 clk = ~clk;

  conv3x3_stream #(.SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  conv3x3_stream #(.SHIFT(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .s_valid(s_valid), .s_ready(s_ready_s2), .s_data(s_data),
    .m_valid(m_valid_s2), .m_ready(m_ready), .m_data(m_data_s2), .m_last(m_last_s2),
    .busy(busy_s2)
  );

  typedef struct {
    logic signed [7:0] ctr_coef;
    logic signed [7:0] other_coef;
    int pix_base;
    int pix_step;
    int exp_main [4];
    int exp_s2 [4];
  } vec_t;

  typedef struct {
    int data;
    int data_s2;
    int last;
  } exp_t;

  exp_t sb [$];
  vec_t vecs [4];
  vec_t vec_seven;
  vec_t vec_zero;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_valid_cyc = 0;
  bit valid_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compare every consumed result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (m_valid && !valid_seen) begin
      valid_seen = 1'b1;
      first_valid_cyc = cyc;
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected result", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("m_data", m_data, e.data);
        checkOutput("m_data shift2", m_data_s2, e.data_s2);
        checkOutput("m_last", m_last, e.last);
        checkOutput("m_last shift2", m_last_s2, e.last);
        checkOutput("m_valid shift2", m_valid_s2, 1);
      end
    end
  end

  task automatic writeCoef(input int addr, input int data);
    coef_we = 1'b1;
    coef_addr = addr[3:0];
    coef_data = data[7:0];
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic loadKernel(input logic signed [7:0] ctr, input logic signed [7:0] other);
    for (int i = 0; i < 9; i++) writeCoef(i, (i == 4) ? int'(ctr) : int'(other));
  endtask

  task automatic sendPixel(input int p, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = p[7:0];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("s_ready timeout", 0, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    s_valid = 1'b0;
  endtask

  // Drive one 4x4 frame; expected results are queued as their pixels are driven.
  task automatic applyStimulus(input vec_t v, input bit write_mid, output int acc10);
    int k, acc;
    exp_t e;
    k = 0;
    acc10 = 0;
    for (int idx = 0; idx < 16; idx++) begin
      if (write_mid && idx == 5) writeCoef(4, 7);
      if ((idx / 4) >= 2 && (idx % 4) >= 2) begin
        e.data = v.exp_main[k];
        e.data_s2 = v.exp_s2[k];
        e.last = (k == 3) ? 1 : 0;
        sb.push_back(e);
        k++;
      end
      sendPixel(v.pix_base + v.pix_step * idx, acc);
      if (idx == 0) checkOutput("busy after first pixel", busy, 1);
      if (idx == 10) acc10 = acc;
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !m_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checkOutput("drain timeout", 0, 1);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic checkReset();
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset m_last", m_last, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset s_ready", s_ready, 1);
    checkOutput("reset busy shift2", busy_s2, 0);
    checkOutput("reset s_ready shift2", s_ready_s2, 1);
  endtask

  task automatic stallBranch();
    logic signed [8:0] held;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("stall wait m_valid", 0, 1);
    m_ready = 1'b0;
    held = m_data;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall s_ready", s_ready, 0);
      checkOutput("stall m_valid", m_valid, 1);
      checkOutput("stall m_data", m_data, held);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
  endtask

  initial begin
    int acc10, dummy;

    vecs[0].ctr_coef = 8'sd1;  vecs[0].other_coef = 8'sd0;
    vecs[0].pix_base = 0;      vecs[0].pix_step = 1;
    vecs[0].exp_main = '{5, 6, 9, 10};
    vecs[0].exp_s2   = '{1, 1, 2, 2};
    vecs[1].ctr_coef = 8'sd1;  vecs[1].other_coef = 8'sd1;
    vecs[1].pix_base = 255;    vecs[1].pix_step = 0;
    vecs[1].exp_main = '{255, 255, 255, 255};
    vecs[1].exp_s2   = '{255, 255, 255, 255};
    vecs[2].ctr_coef = -8'sd1; vecs[2].other_coef = -8'sd1;
    vecs[2].pix_base = 100;    vecs[2].pix_step = 0;
    vecs[2].exp_main = '{-256, -256, -256, -256};
    vecs[2].exp_s2   = '{-225, -225, -225, -225};
    vecs[3].ctr_coef = 8'sd1;  vecs[3].other_coef = 8'sd1;
    vecs[3].pix_base = 4;      vecs[3].pix_step = 0;
    vecs[3].exp_main = '{36, 36, 36, 36};
    vecs[3].exp_s2   = '{9, 9, 9, 9};
    vec_seven = vecs[0];
    vec_seven.exp_main = '{35, 42, 63, 70};
    vec_seven.exp_s2   = '{8, 10, 15, 17};
    vec_zero = vecs[0];
    vec_zero.exp_main = '{0, 0, 0, 0};
    vec_zero.exp_s2   = '{0, 0, 0, 0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset();
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      loadKernel(vecs[v].ctr_coef, vecs[v].other_coef);
      valid_seen = 1'b0;
      applyStimulus(vecs[v], 1'b0, acc10);
      waitDrain();
      checkOutput("busy after frame", busy, 0);
      if (v == 0) checkOutput("latency pixel10 to m_valid", first_valid_cyc - acc10, 3);
    end

    $display("[TB] backpressure stall mid-frame");
    loadKernel(8'sd1, 8'sd0);
    fork
      applyStimulus(vecs[0], 1'b0, dummy);
      stallBranch();
    join
    waitDrain();

    $display("[TB] coefficient write while busy");
    applyStimulus(vecs[0], 1'b1, dummy);
    waitDrain();
    writeCoef(4, 7);
    applyStimulus(vec_seven, 1'b0, dummy);
    waitDrain();

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 9; i++) sendPixel(i, dummy);
    checkOutput("busy mid-frame", busy, 1);
    rst_n = 1'b0;
    #1;
    checkReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(vec_zero, 1'b0, dummy);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 convolution engine: takes a raster-order pixel stream of an IMG_W x IMG_H frame and emits one saturated signed result per fully-interior window ("valid" convolution, (IMG_W-2)*(IMG_H-2) results per frame). It is the parametrised successor to the fixed 4x4 convolution array under the CNN top: runtime-loadable kernel, configurable frame size and widths, valid/ready backpressure. It sits between the pixel source and the activation/pooling stage.

## Interface
- DATA_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width
- OUT_W, 9, signed result width after saturation
- IMG_W, 4, frame columns (>=3)
- IMG_H, 4, frame rows (>=3)
- SHIFT, 0, arithmetic right shift applied to the sum before saturation
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, row-major (0 = top-left); 9..15 ignored
- coef_data  in  COEF_W  signed coefficient
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- s_data  in  DATA_W  pixel, unsigned
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid && m_ready
- m_data  out  OUT_W  signed saturated result
- m_last  out  1  marks the final result of a frame
- busy  out  1  high from first accepted pixel of a frame until its last result is consumed

## Operation
- Reset: coefficients = 0, col/row counters = 0, all stage valids = 0; outputs m_valid=0, m_data=0, m_last=0, busy=0, s_ready=1.
- Global advance en = !(m_valid && !m_ready); s_ready = en. No stage moves when en=0.
- Accept: pixel shifts into the 3x3 window (right column) and into two IMG_W-deep line buffers; col increments, wraps at IMG_W-1 to 0 with row++; row wraps at IMG_H-1 to 0 (frame end), next pixel starts a new frame with no gap required.
- Window valid when the accepted pixel has row>=2 && col>=2; window last when row=IMG_H-1 && col=IMG_W-1.
- Stage 1: nine products pixel(zero-extended, signed) x coef, width DATA_W+COEF_W+1.
- Stage 2: sum of nine products (product width+4), arithmetic >>SHIFT, saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register into m_data/m_valid/m_last.
- Coefficient write: applied on the edge coef_we=1 when busy=0; writes while busy=1 or addr>8 are dropped.
- Line-buffer contents are not cleared at frame start; rows 0-1 of a frame never produce results, so stale data is never used.
- rst_n low mid-frame: everything above returns to reset values immediately, including coefficients; partial frame discarded.

## Timing
- Latency: result for a window appears on m_valid the 3rd rising edge after the edge accepting the window's bottom-right pixel (window reg, products, sum/sat), absent stalls.
- Throughput: one pixel per cycle while m_ready=1.
- m_data/m_last stable while m_valid && !m_ready; s_ready falls combinationally in that same cycle.
- busy rises on the accept edge of a frame's first pixel, falls on the edge the m_last result is consumed (unless a new frame's first pixel is accepted on that edge, then stays 1).

## Structure
- Shared package cnn_pkg: DATA_W/COEF_W/OUT_W defaults, kernel size constant K=3, saturate function (signed in, OUT_W out).
- Sub-module conv_line_buf: parametrised DATA_W x IMG_W shift/circular buffer with enable, instantiated twice.

## Test plan
- Identity kernel (coef 4 = 1, others 0), 4x4 frame pixels 0..15 -> results 5,6,9,10; m_last only on 10; first m_valid 3 cycles after pixel 10 accepted.
- All coefs = 1, all pixels 255 -> sum 2295 saturates to +255 on each of 4 results; coefs = -1, pixels 100 -> -900 saturates to -256.
- SHIFT=2, all coefs 1, pixels 4 -> 36>>2 = 9.
- m_ready held low 5 cycles mid-frame -> s_ready=0, m_data unchanged, no pixel lost; result sequence identical to unstalled run.
- coef_we during busy (addr 4 = 7) -> ignored, results unchanged; same write after busy falls -> next frame uses 7.
- rst_n pulsed after 9 pixels -> m_valid=0, busy=0, coefs=0; fresh frame afterwards yields 4 zero results with correct m_last.
